// File: rtl/branch_resolver.sv
// branch_resolver: resolves conditional branches from the comparator flags,
// serves one-cycle-latency predictions from a PC-indexed table of 2-bit
// saturating counters, and keeps branch / mispredict statistics.
module branch_resolver #(
    parameter int         DWIDTH     = 32,
    parameter int         ENTRIES    = 64,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              lookup_valid,
    input  logic [DWIDTH-1:0] lookup_pc,
    output logic              pred_valid,
    output logic              pred_taken,

    input  logic              resolve_valid,
    input  logic [DWIDTH-1:0] resolve_pc,
    input  logic [2:0]        resolve_funct3,
    input  logic              resolve_pred,

    output logic              br_un,
    input  logic              br_eq,
    input  logic              br_lt,

    output logic              actual_taken,
    output logic              mispredict,
    output logic [DWIDTH-1:0] num_branches,
    output logic [DWIDTH-1:0] num_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Predictor table: one 2-bit saturating counter per entry
    logic [1:0] counters [ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] resolve_idx;

    logic cond_taken;
    logic legal;
    logic do_update;
    logic is_mispredict;

    logic [1:0] cur_cnt;
    logic [1:0] next_cnt;

    // Word-aligned PCs: bits [1:0] and everything above the index are dropped,
    // so branches that differ only in those bits share a counter.
    assign lookup_idx  = lookup_pc[IDX_W+1:2];
    assign resolve_idx = resolve_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[DWIDTH-1:IDX_W+2], lookup_pc[1:0],
                              resolve_pc[DWIDTH-1:IDX_W+2], resolve_pc[1:0]};

    // The comparator needs to know whether to compare unsigned (BLTU/BGEU)
    assign br_un = resolve_funct3[1];

    // Decode funct3 into the branch condition and flag the illegal encodings
    always_comb begin
        legal      = 1'b1;
        cond_taken = 1'b0;
        case (resolve_funct3)
            3'b000:         cond_taken = br_eq;
            3'b001:         cond_taken = !br_eq;
            3'b100, 3'b110: cond_taken = br_lt;
            3'b101, 3'b111: cond_taken = !br_lt;
            default:        legal      = 1'b0;
        endcase
    end

    assign do_update     = resolve_valid & legal;
    assign actual_taken  = do_update & cond_taken;
    assign is_mispredict = do_update & (actual_taken != resolve_pred);

    assign cur_cnt = counters[resolve_idx];

    // Saturating increment on taken, saturating decrement on not-taken
    always_comb begin
        next_cnt = cur_cnt;
        if (actual_taken) begin
            if (cur_cnt != 2'b11) begin
                next_cnt = cur_cnt + 2'd1;
            end
        end else begin
            if (cur_cnt != 2'b00) begin
                next_cnt = cur_cnt - 2'd1;
            end
        end
    end

    // Counter table write port; a same-edge lookup still sees the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= INIT_STATE;
            end
        end else if (do_update) begin
            counters[resolve_idx] <= next_cnt;
        end
    end

    // Registered prediction; pred_taken holds when no lookup is requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= lookup_valid;
            if (lookup_valid) begin
                pred_taken <= counters[lookup_idx][1];
            end
        end
    end

    // Mispredict pulse and statistics, all updated on the edge after resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict      <= 1'b0;
            num_branches    <= '0;
            num_mispredicts <= '0;
        end else begin
            mispredict <= is_mispredict;
            if (do_update) begin
                num_branches <= num_branches + 1'b1;
            end
            if (is_mispredict) begin
                num_mispredicts <= num_mispredicts + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver: reset, decode, counter saturation,
// mispredict pulses, read-before-write collision, aliasing and counter wrap.
module tb_branch_resolver;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic [2:0]  resolve_funct3;
    logic        resolve_pred;
    logic        br_un;
    logic        br_eq;
    logic        br_lt;
    logic        actual_taken;
    logic        mispredict;
    logic [31:0] num_branches;
    logic [31:0] num_mispredicts;

    // Narrow instance used only to exercise statistics wrap-around
    logic        w_lookup_valid;
    logic [7:0]  w_lookup_pc;
    logic        w_pred_valid;
    logic        w_pred_taken;
    logic        w_resolve_valid;
    logic [7:0]  w_resolve_pc;
    logic [2:0]  w_resolve_funct3;
    logic        w_resolve_pred;
    logic        w_br_un;
    logic        w_br_eq;
    logic        w_br_lt;
    logic        w_actual_taken;
    logic        w_mispredict;
    logic [7:0]  w_num_branches;
    logic [7:0]  w_num_mispredicts;

    int num_compared;
    int num_mismatched;

    branch_resolver #(.DWIDTH(32), .ENTRIES(64), .INIT_STATE(2'b01)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lookup_valid    (lookup_valid),
        .lookup_pc       (lookup_pc),
        .pred_valid      (pred_valid),
        .pred_taken      (pred_taken),
        .resolve_valid   (resolve_valid),
        .resolve_pc      (resolve_pc),
        .resolve_funct3  (resolve_funct3),
        .resolve_pred    (resolve_pred),
        .br_un           (br_un),
        .br_eq           (br_eq),
        .br_lt           (br_lt),
        .actual_taken    (actual_taken),
        .mispredict      (mispredict),
        .num_branches    (num_branches),
        .num_mispredicts (num_mispredicts)
    );

    branch_resolver #(.DWIDTH(8), .ENTRIES(64), .INIT_STATE(2'b01)) dut_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .lookup_valid    (w_lookup_valid),
        .lookup_pc       (w_lookup_pc),
        .pred_valid      (w_pred_valid),
        .pred_taken      (w_pred_taken),
        .resolve_valid   (w_resolve_valid),
        .resolve_pc      (w_resolve_pc),
        .resolve_funct3  (w_resolve_funct3),
        .resolve_pred    (w_resolve_pred),
        .br_un           (w_br_un),
        .br_eq           (w_br_eq),
        .br_lt           (w_br_lt),
        .actual_taken    (w_actual_taken),
        .mispredict      (w_mispredict),
        .num_branches    (w_num_branches),
        .num_mispredicts (w_num_mispredicts)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lv, input logic [31:0] lpc,
                                 input logic rv, input logic [31:0] rpc,
                                 input logic [2:0] f3, input logic pred,
                                 input logic eq, input logic lt);
        lookup_valid   = lv;
        lookup_pc      = lpc;
        resolve_valid  = rv;
        resolve_pc     = rpc;
        resolve_funct3 = f3;
        resolve_pred   = pred;
        br_eq          = eq;
        br_lt          = lt;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Async reset pulse entirely inside the low clock phase
    task automatic pulseReset();
        idleInputs();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [2:0] f3_list   [7];
    logic [2:0] taken_tab [7];
    logic       br_un_tab [7];

    initial begin
        logic        legal;
        logic        exp_taken;
        int          exp_nb;
        int          exp_nm;

        num_compared   = 0;
        num_mismatched = 0;

        // Decode table; bit k of taken_tab is the outcome for (eq,lt) = 00, 01, 10
        f3_list   = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
        taken_tab = '{3'b100, 3'b011, 3'b010, 3'b101, 3'b010, 3'b101, 3'b000};
        br_un_tab = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};

        idleInputs();
        w_lookup_valid   = 1'b0;
        w_lookup_pc      = 8'h0;
        w_resolve_valid  = 1'b0;
        w_resolve_pc     = 8'h0;
        w_resolve_funct3 = 3'b000;
        w_resolve_pred   = 1'b0;
        w_br_eq          = 1'b0;
        w_br_lt          = 1'b0;

        // ---------------- power-on reset ----------------
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("por_pred_valid", {31'b0, pred_valid}, 32'h0);
        checkOutput("por_nb", num_branches, 32'h0);

        // ---------------- build up state, then async reset mid-cycle ----------------
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h40, 3'b000, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("pre_pred_valid", {31'b0, pred_valid}, 32'h1);
        checkOutput("pre_pred_taken", {31'b0, pred_taken}, 32'h0);
        checkOutput("pre_mispredict", {31'b0, mispredict}, 32'h1);
        checkOutput("pre_nb", num_branches, 32'h1);
        nextCycle();
        checkOutput("pre2_pred_taken", {31'b0, pred_taken}, 32'h1);
        checkOutput("pre2_nm", num_mispredicts, 32'h2);
        idleInputs();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_pred_valid", {31'b0, pred_valid}, 32'h0);
        checkOutput("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        checkOutput("rst_mispredict", {31'b0, mispredict}, 32'h0);
        checkOutput("rst_nb", num_branches, 32'h0);
        checkOutput("rst_nm", num_mispredicts, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("rst_lookup_valid", {31'b0, pred_valid}, 32'h1);
        checkOutput("rst_lookup_taken", {31'b0, pred_taken}, 32'h0);

        // ---------------- decode sweep ----------------
        pulseReset();
        exp_nb = 0;
        exp_nm = 0;
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1'b0, 32'h0, 1'b1, 32'h300, f3_list[i], 1'b0,
                              (k == 2), (k == 1));
                #1;
                legal     = (i != 6);
                exp_taken = taken_tab[i][k];
                checkOutput($sformatf("br_un_f%0d_c%0d", f3_list[i], k),
                            {31'b0, br_un}, {31'b0, br_un_tab[i]});
                checkOutput($sformatf("taken_f%0d_c%0d", f3_list[i], k),
                            {31'b0, actual_taken}, {31'b0, exp_taken});
                if (legal) begin
                    exp_nb++;
                    if (exp_taken) exp_nm++;
                end
                nextCycle();
                checkOutput($sformatf("mp_f%0d_c%0d", f3_list[i], k),
                            {31'b0, mispredict}, {31'b0, legal & exp_taken});
                checkOutput($sformatf("nb_f%0d_c%0d", f3_list[i], k),
                            num_branches, exp_nb);
            end
        end
        checkOutput("sweep_nm", num_mispredicts, exp_nm);
        // BNE with eq=0 would be taken, but no resolve is in flight
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h300, 3'b001, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("taken_when_idle", {31'b0, actual_taken}, 32'h0);

        // ---------------- saturation at PC 0x100 ----------------
        pulseReset();
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 3'b000, 1'b1, 1'b1, 1'b0);
            nextCycle();
            applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
            nextCycle();
            checkOutput($sformatf("sat_taken_%0d", n), {31'b0, pred_taken}, 32'h1);
        end
        // From 11: one not-taken leaves weak-taken, the second reaches weak-not-taken
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 3'b000, 1'b1, 1'b0, 1'b0);
            nextCycle();
            applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
            nextCycle();
            checkOutput($sformatf("sat_nt_%0d", n), {31'b0, pred_taken},
                        (n == 0) ? 32'h1 : 32'h0);
        end

        // ---------------- mispredict pulses ----------------
        pulseReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h80, 3'b001, 1'b1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("mp_pulse", {31'b0, mispredict}, 32'h1);
        checkOutput("mp_nm", num_mispredicts, 32'h1);
        checkOutput("mp_nb", num_branches, 32'h1);
        idleInputs();
        nextCycle();
        checkOutput("mp_pulse_end", {31'b0, mispredict}, 32'h0);
        checkOutput("mp_nm_hold", num_mispredicts, 32'h1);
        // Two mispredicting resolves back-to-back, then a correct one
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h80, 3'b100, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("mp_b2b_0", {31'b0, mispredict}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h84, 3'b111, 1'b1, 1'b0, 1'b1);
        nextCycle();
        checkOutput("mp_b2b_1", {31'b0, mispredict}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h88, 3'b101, 1'b1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("mp_correct", {31'b0, mispredict}, 32'h0);
        checkOutput("mp_nm_total", num_mispredicts, 32'h3);
        checkOutput("mp_nb_total", num_branches, 32'h4);

        // ---------------- same-cycle lookup/resolve collision ----------------
        pulseReset();
        applyStimulus(1'b1, 32'h200, 1'b1, 32'h200, 3'b000, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("coll_pred_old", {31'b0, pred_taken}, 32'h0);
        applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("coll_pred_new", {31'b0, pred_taken}, 32'h1);
        idleInputs();
        nextCycle();
        checkOutput("nolookup_valid", {31'b0, pred_valid}, 32'h0);
        checkOutput("nolookup_hold", {31'b0, pred_taken}, 32'h1);

        // ---------------- aliasing ----------------
        pulseReset();
        repeat (2) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h004, 3'b000, 1'b0, 1'b1, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h104, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("alias_104", {31'b0, pred_taken}, 32'h1);
        applyStimulus(1'b1, 32'h008, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("neighbour_008", {31'b0, pred_taken}, 32'h0);
        idleInputs();

        // ---------------- statistics wrap on the 8-bit instance ----------------
        pulseReset();
        w_resolve_valid  = 1'b1;
        w_resolve_pc     = 8'h10;
        w_resolve_funct3 = 3'b000;
        w_resolve_pred   = 1'b0;
        w_br_eq          = 1'b1;
        repeat (255) nextCycle();
        checkOutput("wrap_nb_255", {24'b0, w_num_branches}, 32'hFF);
        checkOutput("wrap_nm_255", {24'b0, w_num_mispredicts}, 32'hFF);
        nextCycle();
        w_resolve_valid = 1'b0;
        checkOutput("wrap_nb_0", {24'b0, w_num_branches}, 32'h0);
        checkOutput("wrap_nm_0", {24'b0, w_num_mispredicts}, 32'h0);
        nextCycle();
        checkOutput("wrap_nb_hold", {24'b0, w_num_branches}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
